bit_serial_datapath: RTL
========================

Name: bit_serial_datapath

Overview:
- Datapath end of the control interface driven by the CPU control FSM.
- Holds operand shift registers A and B, a 1-bit serial ALU with carry flop, a result shift register R, an output register O and the bit counter.
- Consumes the FSM's load/shift/ALU/counter strobes and returns bit_done.
- Processes operands LSB-first, one bit per clock; presents the result both in parallel and as a serial stream.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit counter width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- data_a_in  input  WIDTH  parallel operand A (register value)
- data_b_in  input  WIDTH  parallel operand B (register value or zero-extended immediate)
- sub  input  1  1 = subtract: invert B bit, carry seeded to 1
- load_a  input  1  A <= data_a_in
- load_b  input  1  B <= data_b_in
- shift_a  input  1  shift A right one bit; compute ALU bit; shift R
- shift_b  input  1  shift B right one bit
- alu_op  input  2  00 ADD, 01 XOR, 10 AND, 11 OR
- carry_en  input  1  1 = carry flop feeds adder and updates; 0 = carry-in forced 0, flop holds
- clr_counter  input  1  counter <= 0, carry <= sub
- en_counter  input  1  counter increment
- load_out  input  1  O <= R, carry_out <= carry
- shift_out  input  1  shift O right one bit, fill 0
- bit_done  output  1  combinational: en_counter && count == WIDTH-1
- serial_out  output  1  O[0]
- result  output  WIDTH  O, parallel
- carry_out  output  1  final carry latched at load_out

Behaviour:
- Reset (rst=1 at a clock edge): A, B, R, O, count = 0; carry = 0; carry_out = 0; serial_out = 0.
  - Reset overrides every strobe, including mid-operation.
  - bit_done is 0 while count = 0 and en_counter = 0.
- Per-bit ALU (combinational), from a0 = A[0], b0 = B[0] ^ sub, c = carry & carry_en:
  - ADD: bit = a0^b0^c; cout = (a0&b0) | (c&(a0^b0)).
  - XOR: a0^b0. AND: a0&b0. OR: a0|b0.
  - cout is computed for every op; it is only stored when alu_op = 00.
- On shift_a (and no load_a):
  - A <= {1'b0, A[WIDTH-1:1]}.
  - R <= {bit, R[WIDTH-1:1]}.
  - If carry_en && alu_op == 00: carry <= cout.
- On shift_b (and no load_b): B <= {1'b0, B[WIDTH-1:1]}.
- Load priority: load beats shift on the same register in the same cycle.
- Counter:
  - clr_counter beats en_counter.
  - en_counter increments count; wraps to 0 when count == WIDTH-1.
  - bit_done is high for exactly that one cycle.
  - en_counter with no shift is legal: it counts only.
- Operation latency:
  - After clr_counter, WIDTH cycles of shift_a/shift_b/en_counter complete one operation.
  - R is valid the cycle after the cycle in which bit_done is high.
  - Subtraction: sub = 1 at clr_counter seeds carry = 1; sub must stay stable through the operation.
- Output register:
  - load_out: O <= R; carry_out <= carry.
  - shift_out: O <= {1'b0, O[WIDTH-1:1]}, so serial_out presents the result LSB-first, one bit per shift_out cycle.
  - load_out beats shift_out.
  - After WIDTH shift_outs, O = 0.
- Simultaneous strobes are independent except for the priorities listed above.
  - Example: shift_out during an execute is legal and does not disturb R.
- No internal FSM; state is sequenced entirely by the controller. Undefined alu_op does not exist (2-bit, all decoded).

Test Plan:
- ADD: load A=0x5A, B=0x33, sub=0, clr, 8 shift/en cycles, load_out -> result=0x8D, carry_out=0, bit_done high only on the 8th en cycle.
- ADD carry: A=0xF0, B=0x20 -> result=0x10, carry_out=1. Same operands with carry_en=0 -> result=0xD0, carry_out=0.
- SUB: A=0x10, B=0x01, sub=1 -> result=0x0F, carry_out=1. A=0x01, B=0x02 -> result=0xFF, carry_out=0.
- Logic: A=0xCC, B=0xAA -> XOR 0x66, AND 0x88, OR 0xEE; carry_out unchanged from the prior op.
- Serialise: after the result 0x8D, load_out then 8 shift_out -> serial_out = 1,0,1,1,0,0,0,1, then 0. Counter wraps: a 9th en gives count=1 and bit_done=0.
- Reset mid-execute: rst after 3 shift cycles -> all registers 0 and bit_done=0 next cycle; a subsequent full ADD of 0x01+0x01 gives 0x02.

Source files
------------

// File: rtl/bit_serial_datapath.sv
// Bit-serial datapath controlled by an external sequencer.
// Operands A and B shift out LSB-first through a 1-bit ALU that has a carry
// flop. Each ALU bit shifts into result register R. R copies into output
// register O, which can be read in parallel or shifted out serially.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   data_a_in/_b_in   parallel operands
//   sub               subtract mode: B bit inverted, carry seeded to 1
//   load_a/load_b     parallel operand load (load beats shift)
//   shift_a/shift_b   shift operands; shift_a also computes a bit into R
//   alu_op            00 ADD, 01 XOR, 10 AND, 11 OR
//   carry_en          carry flop feeds adder and updates when set
//   clr_counter       counter <= 0, carry <= sub (beats en_counter)
//   en_counter        bit counter increment, wraps at WIDTH-1
//   load_out          O <= R, carry_out <= carry (beats shift_out)
//   shift_out         O shifts right, zero fill
//   bit_done          combinational: last bit of the operation this cycle
//   serial_out        O[0]
//   result            O
//   carry_out         carry latched at load_out
module bit_serial_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a_in,
  input  logic [WIDTH-1:0] data_b_in,
  input  logic             sub,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             shift_a,
  input  logic             shift_b,
  input  logic [1:0]       alu_op,
  input  logic             carry_en,
  input  logic             clr_counter,
  input  logic             en_counter,
  input  logic             load_out,
  input  logic             shift_out,
  output logic             bit_done,
  output logic             serial_out,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;

  logic a0, b0, cin, alu_bit, alu_cout;

  // One-bit ALU. The carry-out is computed for every op but is stored only
  // for ADD.
  always_comb begin
    a0       = a_q[0];
    b0       = b_q[0] ^ sub;
    cin      = carry_q & carry_en;
    alu_cout = (a0 & b0) | (cin & (a0 ^ b0));
    unique case (alu_op)
      2'b00:   alu_bit = a0 ^ b0 ^ cin;
      2'b01:   alu_bit = a0 ^ b0;
      2'b10:   alu_bit = a0 & b0;
      default: alu_bit = a0 | b0;
    endcase
  end

  // Next-state logic for every register. Each strobe acts on its own
  // register; only the load/shift and clear/enable pairs have priorities.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    if (load_a) begin
      a_d = data_a_in;
    end else if (shift_a) begin
      a_d = {1'b0, a_q[WIDTH-1:1]};
      r_d = {alu_bit, r_q[WIDTH-1:1]};
      if (carry_en && alu_op == 2'b00) carry_d = alu_cout;
    end

    if (load_b)       b_d = data_b_in;
    else if (shift_b) b_d = {1'b0, b_q[WIDTH-1:1]};

    // Clearing the counter starts an operation. In subtract mode it also
    // seeds the carry with 1, which forms the two's-complement +1.
    if (clr_counter) begin
      cnt_d   = '0;
      carry_d = sub;
    end else if (en_counter) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    if (load_out) begin
      o_d    = r_q;
      cout_d = carry_q;
    end else if (shift_out) begin
      o_d = {1'b0, o_q[WIDTH-1:1]};
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bit_done   = en_counter && (cnt_q == CNT_LAST);
  assign serial_out = o_q[0];
  assign result     = o_q;
  assign carry_out  = cout_q;

endmodule
